// File: rtl/systolic_array_4x4.sv
// 4x4 output-stationary-free systolic MAC array: A flows right, B and partial sums flow down.
// All arithmetic is unsigned, truncated and wrapping at DATA_W bits.
module systolic_array_4x4 #(
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              rst_n,
    input  logic              data_clear,
    input  logic              en_b_shift_bottom,
    input  logic              en_shift_right,
    input  logic              en_shift_bottom,
    input  logic [DATA_W-1:0] a_left_in_flat     [0:3],
    input  logic [DATA_W-1:0] b_top_in_flat      [0:3],
    input  logic [DATA_W-1:0] ps_top_in_flat     [0:3],
    output logic [DATA_W-1:0] ps_bottom_out_flat [0:3]
);

    logic [DATA_W-1:0] a_reg  [0:3][0:3];
    logic [DATA_W-1:0] b_reg  [0:3][0:3];
    logic [DATA_W-1:0] ps_reg [0:3][0:3];
    logic [DATA_W-1:0] prod   [0:3][0:3];
    logic [DATA_W-1:0] ps_nxt [0:3][0:3];

    // Products and sums come from pre-edge registers, so a MAC on a shift edge uses old A/B.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                prod[i][j] = a_reg[i][j] * b_reg[i][j];
                if (i == 0)
                    ps_nxt[i][j] = ps_top_in_flat[j] + prod[i][j];
                else
                    ps_nxt[i][j] = ps_reg[i-1][j] + prod[i][j];
            end
        end
    end

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                for (int unsigned j = 0; j < 4; j++) begin
                    a_reg[i][j]  <= '0;
                    b_reg[i][j]  <= '0;
                    ps_reg[i][j] <= '0;
                end
            end
        end else if (data_clear) begin
            for (int unsigned i = 0; i < 4; i++) begin
                for (int unsigned j = 0; j < 4; j++) begin
                    a_reg[i][j]  <= '0;
                    b_reg[i][j]  <= '0;
                    ps_reg[i][j] <= '0;
                end
            end
        end else begin
            if (en_shift_right) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    a_reg[i][0] <= a_left_in_flat[i];
                    for (int unsigned j = 1; j < 4; j++)
                        a_reg[i][j] <= a_reg[i][j-1];
                end
            end
            if (en_b_shift_bottom) begin
                for (int unsigned j = 0; j < 4; j++) begin
                    b_reg[0][j] <= b_top_in_flat[j];
                    for (int unsigned i = 1; i < 4; i++)
                        b_reg[i][j] <= b_reg[i-1][j];
                end
            end
            if (en_shift_bottom) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    for (int unsigned j = 0; j < 4; j++)
                        ps_reg[i][j] <= ps_nxt[i][j];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < 4; j++)
            ps_bottom_out_flat[j] = ps_reg[3][j];
    end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Directed self-checking bench for systolic_array_4x4, with a small reference model
// for the simultaneous-shift scenario.
module tb_systolic_array_4x4;

    localparam int DW = 16;
    typedef logic [DW-1:0] vec_t [0:3];

    logic          Clock;
    logic          rst_n;
    logic          data_clear;
    logic          en_b_shift_bottom;
    logic          en_shift_right;
    logic          en_shift_bottom;
    logic [DW-1:0] a_in   [0:3];
    logic [DW-1:0] b_in   [0:3];
    logic [DW-1:0] ps_in  [0:3];
    logic [DW-1:0] ps_out [0:3];

    logic [DW-1:0] m_a  [0:3][0:3];
    logic [DW-1:0] m_b  [0:3][0:3];
    logic [DW-1:0] m_ps [0:3][0:3];

    int errors = 0;
    int checks = 0;

    systolic_array_4x4 #(.DATA_W(DW)) dut (
        .Clock              (Clock),
        .rst_n              (rst_n),
        .data_clear         (data_clear),
        .en_b_shift_bottom  (en_b_shift_bottom),
        .en_shift_right     (en_shift_right),
        .en_shift_bottom    (en_shift_bottom),
        .a_left_in_flat     (a_in),
        .b_top_in_flat      (b_in),
        .ps_top_in_flat     (ps_in),
        .ps_bottom_out_flat (ps_out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        data_clear        = 1'b0;
        en_b_shift_bottom = 1'b0;
        en_shift_right    = 1'b0;
        en_shift_bottom   = 1'b0;
    endtask

    task automatic shift_a(input vec_t v, input int n);
        a_in = v;
        en_shift_right = 1'b1;
        repeat (n) tick();
        en_shift_right = 1'b0;
    endtask

    task automatic shift_b(input vec_t v, input int n);
        b_in = v;
        en_b_shift_bottom = 1'b1;
        repeat (n) tick();
        en_b_shift_bottom = 1'b0;
    endtask

    task automatic shift_ps(input vec_t v, input int n);
        ps_in = v;
        en_shift_bottom = 1'b1;
        repeat (n) tick();
        en_shift_bottom = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        en_shift_right = 1'b1; en_b_shift_bottom = 1'b1; en_shift_bottom = 1'b1;
        data_clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                a_in[j] = DW'($urandom); b_in[j] = DW'($urandom); ps_in[j] = DW'($urandom);
            end
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ps_out[j] !== '0) begin
                errors++;
                $display("FAIL reset_async_out[%0d]: got %h want 0000", j, ps_out[j]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            en_shift_right = k[0]; en_shift_bottom = ~k[0]; data_clear = k[1];
            for (int j = 0; j < 4; j++) begin
                a_in[j] = DW'($urandom); b_in[j] = DW'($urandom); ps_in[j] = DW'($urandom);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (dut.a_reg[i][j] !== '0 || dut.b_reg[i][j] !== '0 || dut.ps_reg[i][j] !== '0) begin
                    errors++;
                    $display("FAIL reset_regs[%0d][%0d]: got a=%h b=%h ps=%h want 0", i, j,
                             dut.a_reg[i][j], dut.b_reg[i][j], dut.ps_reg[i][j]);
                end
            end
        end
        @(negedge Clock);
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_resume_latency();
        shift_ps('{16'd7, 16'd7, 16'd7, 16'd7}, 3);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ps_out[j] !== 16'd0) begin
                errors++;
                $display("FAIL latency_3edges[%0d]: got %0d want 0", j, ps_out[j]);
            end
        end
        shift_ps('{16'd7, 16'd7, 16'd7, 16'd7}, 1);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ps_out[j] !== 16'd7) begin
                errors++;
                $display("FAIL latency_4edges[%0d]: got %0d want 7", j, ps_out[j]);
            end
        end
    endtask

    task automatic test_mac_pass();
        vec_t exp;
        exp = '{16'd4, 16'd8, 16'd12, 16'd16};
        shift_b('{16'd1, 16'd2, 16'd3, 16'd4}, 4);
        shift_a('{16'd1, 16'd1, 16'd1, 16'd1}, 4);
        shift_ps('{16'd0, 16'd0, 16'd0, 16'd0}, 4);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ps_out[j] !== exp[j]) begin
                errors++;
                $display("FAIL mac_pass[%0d]: got %0d want %0d", j, ps_out[j], exp[j]);
            end
        end
    endtask

    task automatic test_hold();
        vec_t exp;
        exp = '{16'd4, 16'd8, 16'd12, 16'd16};
        idle_inputs();
        for (int j = 0; j < 4; j++) begin
            a_in[j] = 16'hBEEF; b_in[j] = 16'h1234; ps_in[j] = 16'h0F0F;
        end
        repeat (10) tick();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ps_out[j] !== exp[j]) begin
                errors++;
                $display("FAIL hold[%0d]: got %0d want %0d", j, ps_out[j], exp[j]);
            end
        end
    endtask

    task automatic test_single_a();
        vec_t exp;
        exp = '{16'd12, 16'd10, 16'd10, 16'd10};
        shift_a('{16'd0, 16'd0, 16'd0, 16'd0}, 4);
        shift_a('{16'd2, 16'd0, 16'd0, 16'd0}, 1);
        shift_ps('{16'd10, 16'd10, 16'd10, 16'd10}, 4);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ps_out[j] !== exp[j]) begin
                errors++;
                $display("FAIL single_a[%0d]: got %0d want %0d", j, ps_out[j], exp[j]);
            end
        end
    endtask

    task automatic test_overflow();
        shift_b('{16'h0100, 16'h0100, 16'h0100, 16'h0100}, 4);
        shift_a('{16'h0100, 16'h0100, 16'h0100, 16'h0100}, 4);
        shift_ps('{16'h0005, 16'h0005, 16'h0005, 16'h0005}, 4);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ps_out[j] !== 16'h0005) begin
                errors++;
                $display("FAIL overflow_trunc[%0d]: got %h want 0005", j, ps_out[j]);
            end
        end
        shift_b('{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 4);
        shift_a('{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 4);
        shift_ps('{16'h0000, 16'h0000, 16'h0000, 16'h0000}, 4);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ps_out[j] !== 16'h0004) begin
                errors++;
                $display("FAIL overflow_ffff[%0d]: got %h want 0004", j, ps_out[j]);
            end
        end
    endtask

    task automatic test_clear_priority();
        for (int j = 0; j < 4; j++) begin
            a_in[j] = 16'h1111; b_in[j] = 16'h2222; ps_in[j] = 16'h3333;
        end
        data_clear = 1'b1;
        en_shift_right = 1'b1; en_b_shift_bottom = 1'b1; en_shift_bottom = 1'b1;
        tick();
        idle_inputs();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ps_out[j] !== '0) begin
                errors++;
                $display("FAIL clear_out[%0d]: got %h want 0000", j, ps_out[j]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (dut.a_reg[i][j] !== '0 || dut.b_reg[i][j] !== '0 || dut.ps_reg[i][j] !== '0) begin
                    errors++;
                    $display("FAIL clear_regs[%0d][%0d]: got a=%h b=%h ps=%h want 0", i, j,
                             dut.a_reg[i][j], dut.b_reg[i][j], dut.ps_reg[i][j]);
                end
            end
        end
    endtask

    // Reference step: every next value is built only from the pre-edge model state.
    task automatic model_edge();
        logic [DW-1:0] na  [0:3][0:3];
        logic [DW-1:0] nb  [0:3][0:3];
        logic [DW-1:0] nps [0:3][0:3];
        logic [DW-1:0] above;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                na[i][j]  = m_a[i][j];
                nb[i][j]  = m_b[i][j];
                nps[i][j] = m_ps[i][j];
                if (en_shift_right)
                    na[i][j] = (j == 0) ? a_in[i] : m_a[i][(j == 0) ? 0 : j-1];
                if (en_b_shift_bottom)
                    nb[i][j] = (i == 0) ? b_in[j] : m_b[(i == 0) ? 0 : i-1][j];
                if (en_shift_bottom) begin
                    above = (i == 0) ? ps_in[j] : m_ps[(i == 0) ? 0 : i-1][j];
                    nps[i][j] = above + DW'(m_a[i][j] * m_b[i][j]);
                end
            end
        end
        m_a = na; m_b = nb; m_ps = nps;
    endtask

    task automatic test_simultaneous();
        data_clear = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                m_a[i][j] = '0; m_b[i][j] = '0; m_ps[i][j] = '0;
            end
        for (int k = 0; k < 16; k++) begin
            en_shift_right    = (k < 12) && (k % 3 != 2);
            en_b_shift_bottom = (k < 5) || (k == 7);
            en_shift_bottom   = (k >= 1);
            for (int j = 0; j < 4; j++) begin
                a_in[j]  = DW'(k * 3 + j + 1);
                b_in[j]  = DW'(k + 2 * j + 1);
                ps_in[j] = DW'(100 + k * 4 + j);
            end
            model_edge();
            tick();
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (ps_out[j] !== m_ps[3][j]) begin
                    errors++;
                    $display("FAIL simultaneous_c%0d[%0d]: got %h want %h", k, j, ps_out[j], m_ps[3][j]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        for (int j = 0; j < 4; j++) begin
            a_in[j] = '0; b_in[j] = '0; ps_in[j] = '0;
        end
        #12;
        test_reset();
        test_resume_latency();
        test_mac_pass();
        test_hold();
        test_single_a();
        test_overflow();
        test_clear_priority();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
